// File: rtl/frog_judge.sv
`default_nettype none
// ============================================================================
//  Module   : frog_judge
//  Purpose  : Game judge for a frog-crossing game. Each animation tick it
//             tests the frog box against N_OBS obstacle boxes and the screen
//             bounds. It tracks lives and score, and sequences the game
//             through PLAY / DEAD / HOME / OVER.
//  Ports    : i_clk, i_rst_n      - clock, async active-low reset
//             i_ani_stb, i_animate - a tick is i_animate && i_ani_stb
//             i_start             - restart request (honoured in OVER only)
//             i_f_*               - frog box (x1 left, x2 right, y1 top, y2 bottom)
//             i_o_*               - packed obstacle boxes, 12 bits per obstacle
//             o_dead              - high outside PLAY; returns the frog to start
//             o_hit               - collision/out-of-bounds seen on the last tick
//             o_lives, o_score    - remaining lives, frogs brought home
//             o_state, o_game_over - current state, high while in OVER
//  Revision : 1.0 - initial release
// ============================================================================
module frog_judge #(
    parameter int N_OBS       = 4,
    parameter int D_WIDTH     = 640,
    parameter int D_HEIGHT    = 480,
    parameter int GOAL_Y      = 20,
    parameter int LIVES       = 3,
    parameter int HOLD_FRAMES = 30
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_ani_stb,
    input  logic                 i_animate,
    input  logic                 i_start,
    input  logic [11:0]          i_f_x1,
    input  logic [11:0]          i_f_x2,
    input  logic [11:0]          i_f_y1,
    input  logic [11:0]          i_f_y2,
    input  logic [12*N_OBS-1:0]  i_o_x1,
    input  logic [12*N_OBS-1:0]  i_o_x2,
    input  logic [12*N_OBS-1:0]  i_o_y1,
    input  logic [12*N_OBS-1:0]  i_o_y2,
    output logic                 o_dead,
    output logic                 o_hit,
    output logic [2:0]           o_lives,
    output logic [7:0]           o_score,
    output logic [1:0]           o_state,
    output logic                 o_game_over
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The timer only ever holds values from 0 to HOLD_FRAMES-1.
    localparam int TW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    localparam logic [TW-1:0] C_HOLD_LOAD = TW'(HOLD_FRAMES - 1);
    localparam logic [2:0]    C_LIVES     = 3'(LIVES);
    localparam logic [11:0]   C_D_WIDTH   = 12'(D_WIDTH);
    localparam logic [11:0]   C_D_HEIGHT  = 12'(D_HEIGHT);
    localparam logic [11:0]   C_GOAL_Y    = 12'(GOAL_Y);

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_DEAD = 2'd1,
        ST_HOME = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [2:0]     lives_q, lives_d;
    logic [7:0]     score_q, score_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           hit_q,   hit_d;
    logic           dead_q,  dead_d;

    // ------------------------------------------------------------------------
    // Collision detection
    // ------------------------------------------------------------------------
    logic [N_OBS-1:0] w_overlap;
    logic             w_oob;
    logic             w_hit;
    logic             w_tick;

    generate
        for (genvar k = 0; k < N_OBS; k++) begin : g_obs
            logic [11:0] w_x1, w_x2, w_y1, w_y2;
            assign w_x1 = i_o_x1[12*k +: 12];
            assign w_x2 = i_o_x2[12*k +: 12];
            assign w_y1 = i_o_y1[12*k +: 12];
            assign w_y2 = i_o_y2[12*k +: 12];
            // Strict compares: boxes that merely share an edge do not collide.
            assign w_overlap[k] = (i_f_x1 < w_x2) && (i_f_x2 > w_x1) &&
                                  (i_f_y1 < w_y2) && (i_f_y2 > w_y1);
        end
    endgenerate

    always_comb begin
        w_tick = i_animate & i_ani_stb;
        // Bit 11 of a left/top edge means the coordinate wrapped below zero.
        w_oob  = i_f_x1[11] | i_f_y1[11] |
                 (i_f_x2 > C_D_WIDTH) | (i_f_y2 > C_D_HEIGHT);
        w_hit  = (|w_overlap) | w_oob;
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        score_d = score_q;
        timer_d = timer_q;
        hit_d   = hit_q;

        // Restart is edge-qualified only by being in OVER, not by a tick.
        if ((state_q == ST_OVER) && i_start) begin
            state_d = ST_PLAY;
            lives_d = C_LIVES;
            score_d = 8'd0;
            timer_d = '0;
        end else if (w_tick) begin
            unique case (state_q)
                ST_PLAY: begin
                    // A collision on the goal line still costs a life.
                    if (w_hit) begin
                        state_d = ST_DEAD;
                        timer_d = C_HOLD_LOAD;
                        if (lives_q != 3'd0) begin
                            lives_d = lives_q - 3'd1;
                        end
                    end else if (i_f_y1 <= C_GOAL_Y) begin
                        state_d = ST_HOME;
                        timer_d = C_HOLD_LOAD;
                        if (score_q != 8'hFF) begin
                            score_d = score_q + 8'd1;
                        end
                    end
                end
                ST_DEAD: begin
                    if (timer_q == '0) begin
                        state_d = (lives_q == 3'd0) ? ST_OVER : ST_PLAY;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                ST_HOME: begin
                    if (timer_q == '0) begin
                        state_d = ST_PLAY;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                ST_OVER: begin
                    state_d = ST_OVER;
                end
                default: begin
                    state_d = ST_PLAY;
                end
            endcase
        end

        // The hit flag reflects every tick, whatever the state.
        if (w_tick) begin
            hit_d = w_hit;
        end

        // Registered alongside the state so o_dead has no input-to-output path.
        dead_d = (state_d != ST_PLAY);
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_PLAY;
            lives_q <= C_LIVES;
            score_q <= 8'd0;
            timer_q <= '0;
            hit_q   <= 1'b0;
            dead_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            score_q <= score_d;
            timer_q <= timer_d;
            hit_q   <= hit_d;
            dead_q  <= dead_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_dead      = dead_q;
    assign o_hit       = hit_q;
    assign o_lives     = lives_q;
    assign o_score     = score_q;
    assign o_state     = state_q;
    assign o_game_over = (state_q == ST_OVER);

endmodule
`default_nettype wire

// File: doc/frog_judge.md
FROG_JUDGE -- requirements
Module: frog_judge

Interface
REQ-001 The block SHALL have parameter N_OBS, default 4, giving the number of obstacle boxes checked.
REQ-002 The block SHALL have parameter D_WIDTH, default 640, giving the display width in pixels.
REQ-003 The block SHALL have parameter D_HEIGHT, default 480, giving the display height in pixels.
REQ-004 The block SHALL have parameter GOAL_Y, default 20; a frog top edge <= GOAL_Y means the frog has reached home.
REQ-005 The block SHALL have parameter LIVES, default 3, giving the lives granted at reset and at restart (range 1-7).
REQ-006 The block SHALL have parameter HOLD_FRAMES, default 30, giving the animation ticks spent in the DEAD and HOME states.
REQ-007 Port i_clk, input, 1 bit: the single clock.
REQ-008 Port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-009 Port i_ani_stb, input, 1 bit: animation strobe, one cycle per frame.
REQ-010 Port i_animate, input, 1 bit: the block advances only while this is high.
REQ-011 Port i_start, input, 1 bit: restart request, honoured only in the OVER state.
REQ-012 Ports i_f_x1, i_f_x2, i_f_y1, i_f_y2, input, 12 bits each: the frog box (left, right, top, bottom).
REQ-013 Ports i_o_x1, i_o_x2, i_o_y1, i_o_y2, input, 12*N_OBS bits each, packed: obstacle k occupies bits [12k+11:12k].
REQ-014 Port o_dead, output, 1 bit: drives the frog return-to-start input.
REQ-015 Port o_hit, output, 1 bit: registered collision or out-of-bounds flag from the last tick.
REQ-016 Port o_lives, output, 3 bits: remaining lives.
REQ-017 Port o_score, output, 8 bits: frogs brought home.
REQ-018 Port o_state, output, 2 bits, encoded as follows:
- PLAY = 0
- DEAD = 1
- HOME = 2
- OVER = 3
REQ-019 Port o_game_over, output, 1 bit: high while the block is in OVER.

Function
REQ-020 The term "tick" SHALL mean a clock edge where i_animate && i_ani_stb; all state, timer, lives and score updates SHALL occur only on ticks, except REQ-031.
REQ-021 Obstacle k SHALL overlap the frog iff all of the following hold (strict unsigned compares):
- i_f_x1 < o_x2[k]
- i_f_x2 > o_x1[k]
- i_f_y1 < o_y2[k]
- i_f_y2 > o_y1[k]
REQ-022 The frog SHALL be out of bounds if any of the following hold:
- bit 11 of i_f_x1 or of i_f_y1 is set (underflow wrap)
- i_f_x2 > D_WIDTH
- i_f_y2 > D_HEIGHT
REQ-023 hit SHALL be the OR of all N_OBS overlaps and out-of-bounds; o_hit SHALL register hit on every tick regardless of state.
REQ-024 In PLAY on a tick, the block SHALL act as follows:
- if hit: go to DEAD, decrement lives by 1, load the timer with HOLD_FRAMES-1;
- else if i_f_y1 <= GOAL_Y: go to HOME, increment score, load the timer with HOLD_FRAMES-1;
- else stay in PLAY.
REQ-025 hit SHALL take priority over reaching home on the same tick.
REQ-026 The score SHALL saturate at 255, and lives SHALL never underflow below 0.
REQ-027 In DEAD on each tick, the timer SHALL decrement; on a tick with the timer at 0, the block SHALL go to OVER if lives == 0, else to PLAY.
REQ-028 In HOME on each tick, the timer SHALL decrement; on a tick with the timer at 0, the block SHALL go to PLAY.
REQ-029 Collisions in DEAD, HOME and OVER SHALL NOT change lives or score.
REQ-030 o_dead SHALL be 1 in DEAD, HOME and OVER, and 0 in PLAY, registered with state so it has no combinational path from the inputs.
REQ-031 In OVER, i_start high on any clock edge (tick not required) SHALL reload lives to LIVES, clear the score and the timer, and go to PLAY on that edge.
REQ-032 i_start SHALL be ignored outside OVER.
REQ-033 o_game_over SHALL equal (state == OVER).
REQ-034 While i_animate is low, all registers SHALL hold their values, except for the OVER-state restart of REQ-031.

Reset
REQ-035 While i_rst_n is low, the block SHALL immediately force the following values:
- state PLAY
- o_lives = LIVES
- o_score = 0
- o_hit = 0
- o_dead = 0
- timer = 0
REQ-036 Reset asserted mid-DEAD or mid-HOME SHALL abort the hold and take effect asynchronously; release SHALL be synchronous to i_clk, and the block SHALL resume in PLAY on the first tick after release.

Verification
REQ-037 Frog box 309..331 x 449..471, obstacle 0 = 300..340 x 440..480, one tick -> required response:
- o_hit = 1, o_state = DEAD, o_dead = 1, o_lives = 2
- after 30 further ticks: o_state = PLAY
REQ-038 Frog box 309..331 x 449..471, obstacle 0 = 331..350 x 449..471 (edges touching only), tick -> o_hit = 0, o_state = PLAY.
REQ-039 Frog top edge = 20, no obstacles overlapping, tick -> required response:
- o_state = HOME, o_score = 1, o_dead = 1
- after 30 ticks: PLAY
- same tick with frog top 20 plus an overlap -> DEAD, o_score unchanged.
REQ-040 Three hits from LIVES = 3 -> required response:
- o_lives = 0
- after the hold: o_state = OVER, o_game_over = 1, held
- i_start pulse with i_animate = 0 -> o_state = PLAY, o_lives = 3, o_score = 0.
REQ-041 Frog i_f_x1 = 12'hFFE (wrapped left edge), tick -> o_hit = 1, DEAD.
REQ-042 Drive the score to 255, then reach home again -> o_score stays 255; assert i_rst_n low mid-HOME -> o_state = PLAY and o_dead = 0 before the next clock edge.
